// File: rtl/rv32imc_1p_wb_if.sv
// Write-back bus bundle for rv32imc_1p_wb.
// Carries the ALU/load/mul-div result ports, the issue scoreboard port, the
// hazard query port and the register-file write port.
//   master : result producers, issue and hazard logic (drives requests)
//   slave  : write-back block (drives readies, stall, conflict, rf write)
interface rv32imc_1p_wb_if;
  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  logic            alu_valid;
  logic [RW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_dat;

  logic            ld_valid;
  logic            ld_ready;
  logic [RW-1:0]   ld_rd;
  logic [XLEN-1:0] ld_dat;

  logic            md_valid;
  logic            md_ready;
  logic [RW-1:0]   md_rd;
  logic [XLEN-1:0] md_dat;

  logic            iss_valid;
  logic [RW-1:0]   iss_rd;

  logic [RW-1:0]   rs1_addr;
  logic [RW-1:0]   rs2_addr;
  logic            stall;
  logic            sb_conflict;

  logic            c_rf_write;
  logic [RW-1:0]   rd_addr;
  logic [XLEN-1:0] rd_dati;

  modport master (
    output alu_valid, alu_rd, alu_dat,
    output ld_valid, ld_rd, ld_dat,
    output md_valid, md_rd, md_dat,
    output iss_valid, iss_rd,
    output rs1_addr, rs2_addr,
    input  ld_ready, md_ready, stall, sb_conflict,
    input  c_rf_write, rd_addr, rd_dati
  );

  modport slave (
    input  alu_valid, alu_rd, alu_dat,
    input  ld_valid, ld_rd, ld_dat,
    input  md_valid, md_rd, md_dat,
    input  iss_valid, iss_rd,
    input  rs1_addr, rs2_addr,
    output ld_ready, md_ready, stall, sb_conflict,
    output c_rf_write, rd_addr, rd_dati
  );
endinterface

// File: rtl/rv32imc_1p_wb.sv
// Single-port register-file write-back arbiter with long-latency scoreboard.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : rv32imc_1p_wb_if.slave (result ports, issue port, hazard port,
//             register-file write port)
// One result per cycle is accepted, priority ALU > load > mul/div, and written
// one cycle later. A 32-bit pending scoreboard tracks load/mul-div destinations.
// Optional feature: define RV32IMC_1P_WB_MDQ_EN to place a 2-entry FIFO on the
// mul/div result port; its head then competes at lowest priority.
module rv32imc_1p_wb (
  input  logic           clk,
  input  logic           reset_n,
  rv32imc_1p_wb_if.slave bus
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned NREG = 32;

  typedef struct packed {
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] dat;
  } wb_res_t;

  // Mul/div source seen by the arbiter (FIFO head or raw port)
  wb_res_t md_head;
  logic    md_head_valid;
  logic    md_ready_int;

`ifdef RV32IMC_1P_WB_MDQ_EN
  localparam int unsigned MDQ_DEPTH = 2;

  wb_res_t    mdq_mem_q [MDQ_DEPTH];
  logic       mdq_wr_ptr_q;
  logic       mdq_rd_ptr_q;
  logic [1:0] mdq_cnt_q;
  logic       mdq_push;
  logic       mdq_pop;

  // Full blocks a push even if the head drains this cycle
  assign md_ready_int  = (mdq_cnt_q != 2'(MDQ_DEPTH));
  assign md_head_valid = (mdq_cnt_q != 2'd0);
  assign md_head       = mdq_mem_q[mdq_rd_ptr_q];
  assign mdq_push      = bus.md_valid & md_ready_int;
  assign mdq_pop       = md_head_valid & ~bus.alu_valid & ~bus.ld_valid;

  // FIFO storage and pointers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(MDQ_DEPTH); i++) mdq_mem_q[i] <= '0;
      mdq_wr_ptr_q <= 1'b0;
      mdq_rd_ptr_q <= 1'b0;
      mdq_cnt_q    <= 2'd0;
    end else begin
      if (mdq_push) begin
        mdq_mem_q[mdq_wr_ptr_q] <= {bus.md_rd, bus.md_dat};
        mdq_wr_ptr_q            <= ~mdq_wr_ptr_q;
      end
      if (mdq_pop) mdq_rd_ptr_q <= ~mdq_rd_ptr_q;
      case ({mdq_push, mdq_pop})
        2'b10:   mdq_cnt_q <= mdq_cnt_q + 2'd1;
        2'b01:   mdq_cnt_q <= mdq_cnt_q - 2'd1;
        default: mdq_cnt_q <= mdq_cnt_q;
      endcase
    end
  end
`else
  assign md_ready_int  = ~bus.alu_valid & ~bus.ld_valid;
  assign md_head_valid = bus.md_valid;
  assign md_head       = {bus.md_rd, bus.md_dat};
`endif

  assign bus.md_ready = md_ready_int;
  assign bus.ld_ready = ~bus.alu_valid;

  // Fixed-priority result select
  wb_res_t sel_res;
  logic    sel_valid;
  logic    sel_clr;

  always_comb begin
    sel_valid = 1'b0;
    sel_clr   = 1'b0;
    sel_res   = '0;
    if (bus.alu_valid) begin
      sel_valid = 1'b1;
      sel_res   = {bus.alu_rd, bus.alu_dat};
    end else if (bus.ld_valid) begin
      sel_valid = 1'b1;
      sel_clr   = 1'b1;
      sel_res   = {bus.ld_rd, bus.ld_dat};
    end else if (md_head_valid) begin
      sel_valid = 1'b1;
      sel_clr   = 1'b1;
      sel_res   = md_head;
    end
  end

  // Write-port and scoreboard registers
  logic            wr_q,   wr_d;
  logic            clr_q,  clr_d;
  logic [RW-1:0]   rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] rd_dati_q, rd_dati_d;
  logic [NREG-1:0] pending_q, pending_d;
  logic            sb_conflict_q, sb_conflict_d;
  logic            iss_set;

  always_comb begin
    wr_d      = sel_valid & (sel_res.rd != '0);
    clr_d     = sel_valid & sel_clr & (sel_res.rd != '0);
    rd_addr_d = rd_addr_q;
    rd_dati_d = rd_dati_q;
    if (sel_valid) begin
      rd_addr_d = sel_res.rd;
      rd_dati_d = sel_res.dat;
    end
  end

  // Clear is applied first so a same-cycle issue to that rd keeps it pending
  always_comb begin
    iss_set   = bus.iss_valid & (bus.iss_rd != '0);
    pending_d = pending_q;
    if (clr_q) pending_d[rd_addr_q] = 1'b0;
    if (iss_set) pending_d[bus.iss_rd] = 1'b1;
    pending_d[0] = 1'b0;
    sb_conflict_d = iss_set & pending_q[bus.iss_rd]
                  & ~(clr_q & (rd_addr_q == bus.iss_rd));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q          <= 1'b0;
      clr_q         <= 1'b0;
      rd_addr_q     <= '0;
      rd_dati_q     <= '0;
      pending_q     <= '0;
      sb_conflict_q <= 1'b0;
    end else begin
      wr_q          <= wr_d;
      clr_q         <= clr_d;
      rd_addr_q     <= rd_addr_d;
      rd_dati_q     <= rd_dati_d;
      pending_q     <= pending_d;
      sb_conflict_q <= sb_conflict_d;
    end
  end

  assign bus.c_rf_write  = wr_q;
  assign bus.rd_addr     = rd_addr_q;
  assign bus.rd_dati     = rd_dati_q;
  assign bus.sb_conflict = sb_conflict_q;

  // Hazard check from the registered scoreboard only
  assign bus.stall = ((bus.rs1_addr != '0) & pending_q[bus.rs1_addr])
                   | ((bus.rs2_addr != '0) & pending_q[bus.rs2_addr]);
endmodule

// File: tb/tb_rv32imc_1p_wb.sv
// Directed self-checking bench for rv32imc_1p_wb. Inputs change 1 time unit
// after a rising edge; outputs are sampled 1-2 time units after the edge.
module tb_rv32imc_1p_wb;
  logic clk;
  logic reset_n;
  int   n_total;
  int   n_pass;

  rv32imc_1p_wb_if bus ();

  rv32imc_1p_wb dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_dat = '0;
    bus.ld_valid  = 1'b0; bus.ld_rd  = '0; bus.ld_dat  = '0;
    bus.md_valid  = 1'b0; bus.md_rd  = '0; bus.md_dat  = '0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0;
    bus.rs1_addr  = '0;   bus.rs2_addr = '0;
  endtask

  initial begin
    bit seen;
    n_total = 0;
    n_pass  = 0;
    idle_inputs();
    reset_n = 1'b0;
    #1;
    // Reset values
    chk("rst_wr",   32'(bus.c_rf_write),  32'd0);
    chk("rst_addr", 32'(bus.rd_addr),     32'd0);
    chk("rst_dat",  bus.rd_dati,          32'd0);
    chk("rst_conf", 32'(bus.sb_conflict), 32'd0);
    chk("rst_stall", 32'(bus.stall),      32'd0);
    chk("rst_ldrdy", 32'(bus.ld_ready),   32'd1);
    chk("rst_mdrdy", 32'(bus.md_ready),   32'd1);
    bus.alu_valid = 1'b1;
    #1;
    chk("rst_ldrdy_alu", 32'(bus.ld_ready), 32'd0);
    bus.alu_valid = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Single ALU write
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_dat = 32'hDEADBEEF;
    tick();
    bus.alu_valid = 1'b0;
    chk("alu_wr",   32'(bus.c_rf_write), 32'd1);
    chk("alu_addr", 32'(bus.rd_addr),    32'd5);
    chk("alu_dat",  bus.rd_dati,         32'hDEADBEEF);
    tick();
    chk("idle_wr",   32'(bus.c_rf_write), 32'd0);
    chk("hold_addr", 32'(bus.rd_addr),    32'd5);
    chk("hold_dat",  bus.rd_dati,         32'hDEADBEEF);

    // Three-way contention
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_dat = 32'hA3A3A3A3;
    bus.ld_valid  = 1'b1; bus.ld_rd  = 5'd4; bus.ld_dat  = 32'hB4B4B4B4;
    bus.md_valid  = 1'b1; bus.md_rd  = 5'd6; bus.md_dat  = 32'hC6C6C6C6;
    #1;
    chk("c0_ldrdy", 32'(bus.ld_ready), 32'd0);
`ifdef RV32IMC_1P_WB_MDQ_EN
    chk("c0_mdrdy", 32'(bus.md_ready), 32'd1);
`else
    chk("c0_mdrdy", 32'(bus.md_ready), 32'd0);
`endif
    tick();
    bus.alu_valid = 1'b0;
`ifdef RV32IMC_1P_WB_MDQ_EN
    bus.md_valid = 1'b0;
`endif
    chk("c1_wr",   32'(bus.c_rf_write), 32'd1);
    chk("c1_addr", 32'(bus.rd_addr),    32'd3);
    chk("c1_dat",  bus.rd_dati,         32'hA3A3A3A3);
    #1;
    chk("c1_ldrdy", 32'(bus.ld_ready), 32'd1);
`ifndef RV32IMC_1P_WB_MDQ_EN
    chk("c1_mdrdy", 32'(bus.md_ready), 32'd0);
`endif
    tick();
    bus.ld_valid = 1'b0;
    chk("c2_wr",   32'(bus.c_rf_write), 32'd1);
    chk("c2_addr", 32'(bus.rd_addr),    32'd4);
    chk("c2_dat",  bus.rd_dati,         32'hB4B4B4B4);
    #1;
    chk("c2_mdrdy", 32'(bus.md_ready), 32'd1);
    tick();
    bus.md_valid = 1'b0;
    chk("c3_wr",   32'(bus.c_rf_write), 32'd1);
    chk("c3_addr", 32'(bus.rd_addr),    32'd6);
    chk("c3_dat",  bus.rd_dati,         32'hC6C6C6C6);
    tick();
    chk("c4_wr", 32'(bus.c_rf_write), 32'd0);

    // Scoreboard stall released by a load write
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd7;
    tick();
    bus.iss_valid = 1'b0;
    bus.rs1_addr  = 5'd7;
    #1;
    chk("sb_stall_set", 32'(bus.stall), 32'd1);
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_dat = 32'h00000012;
    tick();
    bus.ld_valid = 1'b0;
    chk("ld7_wr",    32'(bus.c_rf_write), 32'd1);
    chk("ld7_addr",  32'(bus.rd_addr),    32'd7);
    chk("ld7_dat",   bus.rd_dati,         32'h00000012);
    chk("ld7_stall", 32'(bus.stall),      32'd1);
    tick();
    chk("ld7_stall_fall", 32'(bus.stall), 32'd0);
    bus.rs1_addr = '0;

    // x0 destination
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd0; bus.ld_dat = 32'hFFFFFFFF;
    tick();
    bus.ld_valid = 1'b0;
    chk("x0_wr", 32'(bus.c_rf_write), 32'd0);
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd0;
    tick();
    bus.iss_valid = 1'b0;
    bus.rs1_addr  = 5'd0;
    #1;
    chk("x0_stall", 32'(bus.stall), 32'd0);
    tick();
    chk("x0_stall2", 32'(bus.stall), 32'd0);
    chk("x0_conf",   32'(bus.sb_conflict), 32'd0);

    // Double issue conflict, then issue racing the clearing write
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    tick();
    chk("conf_first", 32'(bus.sb_conflict), 32'd0);
    tick();
    bus.iss_valid = 1'b0;
    chk("conf_pulse", 32'(bus.sb_conflict), 32'd1);
    tick();
    chk("conf_drop", 32'(bus.sb_conflict), 32'd0);
    bus.rs2_addr = 5'd9;
    #1;
    chk("conf_stall", 32'(bus.stall), 32'd1);
    bus.md_valid = 1'b1; bus.md_rd = 5'd9; bus.md_dat = 32'h00000099;
    tick();
    bus.md_valid = 1'b0;
    seen = bus.c_rf_write;
    for (int i = 0; i < 4 && !seen; i++) begin
      tick();
      seen = bus.c_rf_write;
    end
    chk("md9_wr_seen", 32'(seen), 32'd1);
    chk("md9_addr",    32'(bus.rd_addr), 32'd9);
    bus.iss_valid = 1'b1; bus.iss_rd = 5'd9;
    tick();
    bus.iss_valid = 1'b0;
    chk("race_conf",  32'(bus.sb_conflict), 32'd0);
    chk("race_stall", 32'(bus.stall),       32'd1);
    tick();
    chk("race_stall2", 32'(bus.stall), 32'd1);
    bus.rs2_addr = '0;

    // Reset in the middle of traffic
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_dat = 32'h0A0A0A0A;
    bus.md_valid  = 1'b1; bus.md_rd  = 5'd20; bus.md_dat  = 32'h20202020;
`ifdef RV32IMC_1P_WB_MDQ_EN
    tick();
    bus.alu_rd = 5'd11; bus.md_rd = 5'd21; bus.md_dat = 32'h21212121;
    tick();
    bus.md_valid = 1'b0;
    #1;
    chk("mdq_full", 32'(bus.md_ready), 32'd0);
`else
    #1;
`endif
    reset_n = 1'b0;
    bus.alu_valid = 1'b0;
    bus.md_valid  = 1'b0;
    #1;
    chk("mrst_wr",    32'(bus.c_rf_write), 32'd0);
    chk("mrst_mdrdy", 32'(bus.md_ready),   32'd1);
    chk("mrst_dat",   bus.rd_dati,         32'd0);
    bus.rs1_addr = 5'd9;
    #1;
    chk("mrst_stall", 32'(bus.stall), 32'd0);
    bus.rs1_addr = '0;
    tick();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen = seen | bus.c_rf_write;
    end
    chk("post_rst_nowr", 32'(seen), 32'd0);
    chk("post_rst_addr", 32'(bus.rd_addr), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/rv32imc_1p_wb.md
RV32IMC_1P_WB -- requirements
Module: rv32imc_1p_wb

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk in 1 rising-edge clock, reset_n in 1 async active-low reset.
REQ-002 SHALL expose ALU result port: alu_valid in 1, alu_rd in 5, alu_dat in 32; no backpressure.
REQ-003 SHALL expose load result port: ld_valid in 1, ld_ready out 1, ld_rd in 5, ld_dat in 32.
REQ-004 SHALL expose mul/div result port: md_valid in 1, md_ready out 1, md_rd in 5, md_dat in 32.
REQ-005 SHALL expose issue scoreboard port: iss_valid in 1 (long-latency op issued), iss_rd in 5.
REQ-006 SHALL expose hazard port: rs1_addr in 5, rs2_addr in 5, stall out 1, sb_conflict out 1.
REQ-007 SHALL drive register-file write port: c_rf_write out 1, rd_addr out 5, rd_dati out 32.

Function
REQ-008 SHALL accept at most one result per cycle, priority ALU > load > mul/div.
REQ-009 SHALL drive ld_ready = ~alu_valid (combinational).
REQ-010 SHALL register the accepted result: c_rf_write/rd_addr/rd_dati valid exactly one cycle after acceptance.
REQ-011 SHALL drive c_rf_write = 0 when the accepted rd is 0; the result is still consumed.
REQ-012 SHALL hold rd_addr/rd_dati at last values when no result is accepted; c_rf_write = 0.
REQ-013 SHALL keep a 32-bit pending scoreboard; bit 0 never set.
REQ-014 SHALL set pending[iss_rd] on iss_valid with iss_rd != 0.
REQ-015 SHALL clear pending[rd_addr] in the cycle c_rf_write = 1 for a load or mul/div result; ALU writes never clear.
REQ-016 SHALL give set priority over clear when iss_rd equals the clearing rd in the same cycle.
REQ-017 SHALL assert sb_conflict for one cycle when iss_valid targets an already-pending nonzero rd not cleared that cycle; pending bit stays set.
REQ-018 SHALL drive stall = (rs1_addr != 0 & pending[rs1_addr]) | (rs2_addr != 0 & pending[rs2_addr]), combinational from registered scoreboard.
REQ-019 SHALL leave stall asserted in the cycle c_rf_write clears the bit; stall falls the following cycle.
REQ-020 SHALL not reorder results; mul/div data SHALL be written in arrival order.

Reset
REQ-021 SHALL on reset_n = 0 immediately force c_rf_write = 0, rd_addr = 0, rd_dati = 0, sb_conflict = 0, scoreboard = 0, mul/div queue empty.
REQ-022 SHALL discard any accepted-but-unwritten or queued result when reset asserts mid-operation.
REQ-023 SHALL drive stall = 0, ld_ready = ~alu_valid, md_ready per REQ-025/026 during reset.

Configuration
REQ-024 SHALL use macro RV32IMC_1P_WB_MDQ_EN to select a mul/div result queue.
REQ-025 With RV32IMC_1P_WB_MDQ_EN defined: 2-entry FIFO on mul/div port; md_ready = FIFO not full; FIFO head competes at lowest priority; simultaneous push and pop when full not allowed (ready low), when 1 entry allowed.
REQ-026 Without RV32IMC_1P_WB_MDQ_EN: no FIFO; md_ready = ~alu_valid & ~ld_valid; md port competes directly.

Verification
REQ-027 Reset then alu_valid=1, alu_rd=5, alu_dat=0xDEADBEEF -> next cycle c_rf_write=1, rd_addr=5, rd_dati=0xDEADBEEF.
REQ-028 alu_valid, ld_valid, md_valid all 1 (rd 3/4/6) -> ld_ready=0; writes in order rd 3, then 4, then 6 (MDQ_EN: md accepted cycle 0; without: md_ready=0 until cycle 2).
REQ-029 iss_rd=7, then rs1_addr=7 -> stall=1; ld result rd=7, dat=0x12 -> c_rf_write with rd_addr=7, stall=0 the cycle after.
REQ-030 ld_valid with ld_rd=0, dat=0xFFFFFFFF -> c_rf_write stays 0; iss_rd=0 -> stall never asserts for rs1_addr=0.
REQ-031 iss_rd=9 twice without completion -> sb_conflict=1 one cycle; iss_rd=9 same cycle as md write rd 9 -> pending[9] remains 1, no sb_conflict.
REQ-032 MDQ_EN: two md results queued behind ALU stream, reset_n pulsed low -> c_rf_write=0, md_ready=1, no queued write after release.
